// File: rtl/shifter_pkg.sv
// shifter_pkg: shared encodings for the multistep shifter (mode, direction, FSM state)
package shifter_pkg;
    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/multistep_shifter_if.sv
// multistep_shifter_if: start/finished handshake and operand/result bus of the shifter
// Signals: i_start, i_direction, i_mode, i_amount, i_value (requester -> shifter);
// o_busy, o_finished, o_value and, with SHIFTER_CARRY_EN, o_carry (shifter -> requester).
interface multistep_shifter_if #(parameter int N = 8);
    logic         i_start;
    logic         o_busy;
    logic         o_finished;
    logic         i_direction;
    logic [1:0]   i_mode;
    logic [N-1:0] i_amount;
    logic [N-1:0] i_value;
    logic [N-1:0] o_value;
`ifdef SHIFTER_CARRY_EN
    logic         o_carry;
`endif
    modport master (
        output i_start, i_direction, i_mode, i_amount, i_value,
        input  o_busy, o_finished, o_value
`ifdef SHIFTER_CARRY_EN
        , input o_carry
`endif
    );
    modport slave (
        input  i_start, i_direction, i_mode, i_amount, i_value,
        output o_busy, o_finished, o_value
`ifdef SHIFTER_CARRY_EN
        , output o_carry
`endif
    );
endinterface

// File: rtl/shift_step.sv
// shift_step: combinational shift/rotate of value_i by k_i (0..STEP) positions
// Ports: value_i operand, k_i step size, mode_i mode, dir_i direction (1 = left),
// value_o result; with SHIFTER_CARRY_EN, carry_o = last bit shifted out (0 when k_i = 0).
module shift_step
    import shifter_pkg::*;
#(
    parameter int N = 8,
    parameter int STEP = 4,
    localparam int KW = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  value_i,
    input  logic [KW-1:0] k_i,
    input  logic [1:0]    mode_i,
    input  logic          dir_i,
    output logic [N-1:0]  value_o
`ifdef SHIFTER_CARRY_EN
    , output logic        carry_o
`endif
);
    // Operand is placed in a double-width word so the bits pushed out land in the
    // other half: that half supplies both the rotate wrap-around and the carry.
    logic [2*N-1:0] l_ext, r_ext;
    logic signed [2*N-1:0] a_ext;
    logic rot;
    assign l_ext = {{N{1'b0}}, value_i} << k_i;
    assign a_ext = $signed({value_i, {N{1'b0}}}) >>> k_i;
    assign rot = mode_i == MODE_ROTATE;
    always_comb begin
        r_ext = (mode_i == MODE_ARITH && dir_i == DIR_RIGHT) ? a_ext : {value_i, {N{1'b0}}} >> k_i;
        value_o = dir_i == DIR_LEFT ? l_ext[N-1:0] | (rot ? l_ext[2*N-1:N] : '0)
                                    : r_ext[2*N-1:N] | (rot ? r_ext[N-1:0] : '0);
    end
`ifdef SHIFTER_CARRY_EN
    assign carry_o = dir_i == DIR_LEFT ? l_ext[N] : r_ext[N-1];
`endif
endmodule

// File: rtl/multistep_shifter.sv
// multistep_shifter: iterative shifter/rotator moving up to STEP positions per clock
// Ports: i_clock, i_reset (async, active high), bus (multistep_shifter_if.slave).
// Optional macro SHIFTER_CARRY_EN adds bus.o_carry (last bit shifted out).
module multistep_shifter
    import shifter_pkg::*;
#(
    parameter int N = 8,
    parameter int STEP = 4
) (
    input logic i_clock,
    input logic i_reset,
    multistep_shifter_if.slave bus
);
    localparam int KW = $clog2(STEP + 1);
    state_e state_q;
    logic [N-1:0] work_q, rem_q, value_q, step_v, amt_eff;
    logic [1:0] mode_q;
    logic dir_q, busy_q, fin_q;
    logic [KW-1:0] k;
`ifdef SHIFTER_CARRY_EN
    logic step_c, cw_q, over_q, carry_q;
    assign bus.o_carry = carry_q;
`endif
    assign k = rem_q < N'(STEP) ? rem_q[KW-1:0] : KW'(STEP);
    // Shifts saturate at N positions; rotates iterate the full count.
    assign amt_eff = bus.i_mode == MODE_ROTATE ? bus.i_amount
                   : bus.i_amount > N'(N) ? N'(N) : bus.i_amount;
    assign bus.o_busy = busy_q;
    assign bus.o_finished = fin_q;
    assign bus.o_value = value_q;
    shift_step #(.N(N), .STEP(STEP)) u_step (
        .value_i(work_q),
        .k_i(k),
        .mode_i(mode_q),
        .dir_i(dir_q),
        .value_o(step_v)
`ifdef SHIFTER_CARRY_EN
        , .carry_o(step_c)
`endif
    );
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            work_q <= '0;
            rem_q <= '0;
            value_q <= '0;
            mode_q <= MODE_LOGICAL;
            dir_q <= DIR_RIGHT;
            busy_q <= 1'b0;
            fin_q <= 1'b0;
`ifdef SHIFTER_CARRY_EN
            cw_q <= 1'b0;
            over_q <= 1'b0;
            carry_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    fin_q <= 1'b0;
                    if (bus.i_start) begin
                        work_q <= bus.i_value;
                        rem_q <= amt_eff;
                        // reserved encoding behaves as logical
                        mode_q <= (bus.i_mode == MODE_ROTATE || bus.i_mode == MODE_ARITH) ? bus.i_mode : MODE_LOGICAL;
                        dir_q <= bus.i_direction;
                        busy_q <= 1'b1;
                        state_q <= SHIFT;
`ifdef SHIFTER_CARRY_EN
                        cw_q <= 1'b0;
                        over_q <= bus.i_mode != MODE_ROTATE && bus.i_amount > N'(N);
`endif
                    end
                end
                SHIFT: begin
                    work_q <= step_v;
                    rem_q <= rem_q - N'(k);
`ifdef SHIFTER_CARRY_EN
                    if (k != '0) cw_q <= step_c;
`endif
                    if (rem_q == N'(k)) begin
                        busy_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    value_q <= work_q;
                    fin_q <= 1'b1;
                    state_q <= IDLE;
`ifdef SHIFTER_CARRY_EN
                    // past N positions the last bit out is a fill bit
                    carry_q <= over_q ? (mode_q == MODE_ARITH && dir_q == DIR_RIGHT && work_q[N-1]) : cw_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multistep_shifter.sv
// tb_multistep_shifter: scoreboard bench for multistep_shifter (N=8, STEP=4); checks carry when SHIFTER_CARRY_EN is defined
module tb_multistep_shifter;
    import shifter_pkg::*;
    localparam int N = 8;
    localparam int STEP = 4;
    typedef struct {
        logic [N-1:0] v;
        logic c;
        int lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    multistep_shifter_if #(.N(N)) bus ();
    multistep_shifter #(.N(N), .STEP(STEP)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    // Bit-at-a-time reference; looping past N naturally yields fill bits and the fill carry.
    function automatic exp_t model(logic dir, logic [1:0] mode, logic [N-1:0] amt, logic [N-1:0] val);
        exp_t e;
        logic [N-1:0] v = val;
        logic c = 1'b0;
        int a;
        for (int i = 0; i < int'(amt); i++) begin
            if (dir) begin
                c = v[N-1];
                v = {v[N-2:0], mode == MODE_ROTATE ? c : 1'b0};
            end else begin
                c = v[0];
                v = {mode == MODE_ROTATE ? c : (mode == MODE_ARITH ? v[N-1] : 1'b0), v[N-1:1]};
            end
        end
        a = mode == MODE_ROTATE ? int'(amt) : (int'(amt) > N ? N : int'(amt));
        e.v = v;
        e.c = c;
        e.lat = (a == 0 ? 1 : (a + STEP - 1) / STEP) + 1;
        return e;
    endfunction
    // Called at a negedge; returns at the negedge where o_finished is seen.
    task automatic run_op(input logic dir, input logic [1:0] mode, input logic [N-1:0] amt,
                          input logic [N-1:0] val, input int extra = 0);
        exp_t e;
        int cnt = 0;
        int busy_cnt = 0;
        bus.i_start = 1'b1;
        bus.i_direction = dir;
        bus.i_mode = mode;
        bus.i_amount = amt;
        bus.i_value = val;
        sb.push_back(model(dir, mode, amt, val));
        @(negedge clk);
        bus.i_direction = ~dir;
        bus.i_mode = 2'($urandom_range(3, 0));
        bus.i_amount = N'($urandom_range(1, 255));
        bus.i_value = ~val;
        while (bus.o_finished !== 1'b1 && cnt < 50) begin
            busy_cnt += int'(bus.o_busy);
            if (cnt >= extra) bus.i_start = 1'b0;
            @(negedge clk);
            cnt++;
        end
        e = sb.pop_front();
        check("finish_seen", 32'(cnt < 50), 32'd1);
        check("value", 32'(bus.o_value), 32'(e.v));
        check("latency", cnt, e.lat);
        check("busy_cycles", busy_cnt, e.lat - 1);
        check("busy_at_finish", 32'(bus.o_busy), 32'd0);
`ifdef SHIFTER_CARRY_EN
        check("carry", 32'(bus.o_carry), 32'(e.c));
`endif
    endtask
    initial begin
        int seen;
        bus.i_start = 1'b0;
        bus.i_direction = DIR_LEFT;
        bus.i_mode = MODE_LOGICAL;
        bus.i_amount = '0;
        bus.i_value = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_finished", 32'(bus.o_finished), 32'd0);
        check("rst_value", 32'(bus.o_value), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(DIR_LEFT, MODE_LOGICAL, 8'd3, 8'h0F);
        check("lsl_0f_3", 32'(bus.o_value), 32'h78);
        run_op(DIR_RIGHT, MODE_ARITH, 8'd5, 8'h90);
        check("asr_90_5", 32'(bus.o_value), 32'hFC);
        run_op(DIR_RIGHT, MODE_ARITH, 8'd12, 8'h90);
        check("asr_90_12", 32'(bus.o_value), 32'hFF);
        run_op(DIR_RIGHT, MODE_ROTATE, 8'd9, 8'h81);
        check("ror_81_9", 32'(bus.o_value), 32'hC0);
        run_op(DIR_RIGHT, MODE_ROTATE, 8'd8, 8'h81);
        check("ror_81_8", 32'(bus.o_value), 32'h81);
        for (int m = 0; m < 4; m++) begin
            run_op(1'($urandom_range(1, 0)), 2'(m), 8'd0, 8'hA5);
            check("amount0", 32'(bus.o_value), 32'hA5);
        end
        run_op(DIR_LEFT, MODE_LOGICAL, 8'd1, 8'h80);
        check("lsl_80_1", 32'(bus.o_value), 32'h00);
        // start held high with different operands while busy
        run_op(DIR_LEFT, MODE_ROTATE, 8'd9, 8'h81, 2);
        check("rol_81_9", 32'(bus.o_value), 32'h03);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(bus.o_finished);
        end
        check("no_queued_op", seen, 0);
        // reset in the middle of a long rotate
        bus.i_start = 1'b1;
        bus.i_direction = DIR_LEFT;
        bus.i_mode = MODE_ROTATE;
        bus.i_amount = 8'd20;
        bus.i_value = 8'h3C;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        check("busy_before_abort", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_value", 32'(bus.o_value), 32'd0);
        check("abort_finished", 32'(bus.o_finished), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(bus.o_finished);
        end
        check("no_finish_after_abort", seen, 0);
        run_op(DIR_RIGHT, MODE_LOGICAL, 8'd2, 8'hF0);
        check("lsr_f0_2", 32'(bus.o_value), 32'h3C);
        // back-to-back: each new start lands in the IDLE cycle after DONE
        for (int i = 0; i < 12; i++)
            run_op(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                   N'($urandom_range(20, 0)), N'($urandom_range(255, 0)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multistep_shifter.md
Name: multistep_shifter

Overview:
- Iterative shifter/rotator, N-bit operand; shifts by a programmable amount, up to STEP bit positions per clock, instead of one.
- Modes: logical shift, arithmetic shift, rotate.
- Start/finished handshake; result held stable after completion.
- Sits beside the ALU as the multi-cycle shift unit; trades area against latency through STEP.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- STEP, 4, maximum bit positions shifted per cycle (1 <= STEP <= N).

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  request; accepted only when o_busy = 0.
- o_busy  output  1  operation in progress.
- o_finished  output  1  one-cycle pulse, o_value valid.
- i_direction  input  1  1 = left, 0 = right.
- i_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- i_amount  input  N  total bit positions to shift.
- i_value  input  N  operand.
- o_value  output  N  result, held until next accepted start.

Behaviour:
- Reset: asynchronous, active-high. o_busy = 0, o_finished = 0, o_value = 0, state IDLE, internal registers cleared.
- FSM states:
  - IDLE: i_start = 1 → latch i_value, i_amount, i_mode, i_direction; go to SHIFT; o_busy = 1 from the next cycle.
  - SHIFT, each cycle: k = min(remaining, STEP); shift working register by k; remaining -= k. When remaining reaches 0 after this step → DONE.
  - DONE: copy working register to o_value; pulse o_finished for 1 cycle; o_busy = 0 in the same cycle; return to IDLE.
- Latency, start edge to o_finished: max(1, ceil(A/STEP)) + 1 cycles, where A is the effective amount.
  - A = 0: one SHIFT cycle with k = 0; result = operand.
- Effective amount:
  - logical/arithmetic: A = min(i_amount, N), so cycles stay bounded.
  - rotate: A = i_amount; the full count is iterated, no modulo reduction.
- Logical: vacated bits filled with 0. A >= N gives all zeros.
- Arithmetic:
  - right shift fills with the latched MSB; A >= N gives all copies of the sign bit.
  - left shift is identical to logical left.
- Rotate: bits leaving one end enter the other end; rotate by N returns the operand.
- i_start while o_busy = 1, or in the DONE cycle: ignored; no queueing, operands not re-latched.
- Input changes after acceptance have no effect on the operation in progress.
- o_value changes only in the DONE cycle or on reset; it is never an intermediate value.
- Reset mid-operation: aborts immediately; no o_finished pulse.
- Back-to-back operation: i_start held high → a new operation is accepted in the IDLE cycle that follows DONE.

Optional Feature:
- Macro SHIFTER_CARRY_EN.
- Defined:
  - adds output o_carry, 1 bit: the last bit shifted out of the operand (for rotate, the last bit wrapped).
  - updated with o_value in the DONE cycle; 0 when A = 0; 0 on reset.
  - shifts with A > N: o_carry = fill bit.
- Undefined: port absent, no carry logic.

Decomposition:
- Shared package shifter_pkg:
  - mode encodings MODE_LOGICAL, MODE_ARITH, MODE_ROTATE;
  - FSM state encodings IDLE/SHIFT/DONE;
  - direction constants DIR_LEFT, DIR_RIGHT.
- Sub-module shift_step: combinational single-step shifter by k (0..STEP) for a given mode and direction; also produces the step's carry-out bit.
- Top level holds the FSM, the remaining-count register (decrement via the existing Adder), and the working and output registers.

Test Plan:
- N=8, STEP=4, logical left, value 0x0F, amount 3 → o_finished 2 cycles after start, o_value 0x78, busy high for 1 cycle.
- Arithmetic right, value 0x90, amount 5 → 0xFC; amount 12 → 0xFF with latency 3 cycles (A clamped to 8).
- Rotate right, value 0x81, amount 9 → 0xC0 after 4 cycles; amount 8 → 0x81.
- Amount 0, any mode, value 0xA5 → o_value 0xA5, o_finished 2 cycles after start.
- i_start pulsed while busy with different operands → ignored, first result unchanged. Reset asserted mid-SHIFT → immediate clear, no o_finished; next start completes normally.
- SHIFTER_CARRY_EN, logical left, 0x80, amount 1 → o_value 0x00, o_carry 1. STEP=1 build, amount 5 → latency 6 cycles.
